// File: rtl/fixed_point_convert_stream.sv
// Two-stage streaming fixed-point converter: S1 shifts and rounds, S2 range-checks and clamps.
// Define FIXED_POINT_CONVERT_SAT_COUNT_EN to add a saturating count of per-lane saturation events.
`timescale 1ns/1ps
module fixed_point_convert_stream #(
    parameter int LANES     = 3,
    parameter int IN_IBITS  = 24,
    parameter int IN_FBITS  = 40,
    parameter int OUT_IBITS = 12,
    parameter int OUT_FBITS = 20
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_in_valid,
    output logic                                   o_in_ready,
    input  logic [LANES*(IN_IBITS+IN_FBITS)-1:0]   i_in_data,
    input  logic [1:0]                             i_in_round,
    output logic                                   o_out_valid,
    input  logic                                   i_out_ready,
    output logic [LANES*(OUT_IBITS+OUT_FBITS)-1:0] o_out_data,
    output logic [LANES-1:0]                       o_out_sat
`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
    ,
    output logic [31:0]                            o_sat_count,
    input  logic                                   i_sat_count_clr
`endif
);

    localparam int IN_W  = IN_IBITS + IN_FBITS;
    localparam int OUT_W = OUT_IBITS + OUT_FBITS;
    localparam int D     = IN_FBITS - OUT_FBITS;
    localparam int SH_W  = IN_W - D;
    localparam int MID_W = SH_W + 1;
    localparam int CMP_W = (MID_W > OUT_W + 1) ? MID_W : OUT_W + 1;
    localparam int PAD_W = CMP_W - OUT_W + 1;

    localparam logic signed [CMP_W-1:0] SAT_MAX = {{PAD_W{1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = {{PAD_W{1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    logic                   r_s1_valid;
    logic                   r_s2_valid;
    logic [MID_W-1:0]       r_s1_mid [LANES];
    logic [LANES*OUT_W-1:0] r_out_data;
    logic [LANES-1:0]       r_out_sat;

    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic [MID_W-1:0]       w_mid [LANES];
    logic [OUT_W-1:0]       w_res [LANES];
    logic                   w_sat [LANES];

    // S2 frees up when empty or draining; S1 may load whenever it can pass its beat on.
    assign w_s2_adv   = !r_s2_valid || i_out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign o_in_ready = w_s1_adv;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [IN_W-1:0]  w_lane;
        logic signed [CMP_W-1:0] w_cmp;
        logic                    w_hi;
        logic                    w_lo;

        assign w_lane = i_in_data[l*IN_W +: IN_W];

        if (D > 0) begin : g_shr
            logic [SH_W-1:0] w_sh;
            logic            w_g;
            logic            w_s;
            logic            w_inc;

            assign w_sh = w_lane[IN_W-1:D];
            assign w_g  = w_lane[D-1];
            if (D > 1) begin : g_sticky
                assign w_s = |w_lane[D-2:0];
            end else begin : g_nosticky
                assign w_s = 1'b0;
            end

            always_comb begin
                w_inc = 1'b0;
                case (i_in_round)
                    2'b01:   w_inc = w_g;
                    2'b10:   w_inc = w_g & (w_s | w_sh[0]);
                    default: w_inc = 1'b0;
                endcase
            end

            // Extra sign bit keeps a round-up carry from wrapping the top code.
            assign w_mid[l] = {w_sh[SH_W-1], w_sh} + {{SH_W{1'b0}}, w_inc};
        end else begin : g_shl
            logic signed [MID_W-1:0] w_ext;
            assign w_ext    = MID_W'(w_lane);
            assign w_mid[l] = w_ext <<< (-D);
        end

        assign w_cmp    = CMP_W'($signed(r_s1_mid[l]));
        assign w_hi     = w_cmp > SAT_MAX;
        assign w_lo     = w_cmp < SAT_MIN;
        assign w_res[l] = w_hi ? MAX_CODE : (w_lo ? MIN_CODE : w_cmp[OUT_W-1:0]);
        assign w_sat[l] = w_hi | w_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            for (int l = 0; l < LANES; l++) r_s1_mid[l] <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                for (int l = 0; l < LANES; l++) r_s1_mid[l] <= w_mid[l];
            end
        end
    end

    // Output registers only change when S2 advances, so a stalled beat holds steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    r_out_data[l*OUT_W +: OUT_W] <= w_res[l];
                    r_out_sat[l]                 <= w_sat[l];
                end
            end
        end
    end

    assign o_out_valid = r_s2_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sat   = r_out_sat;

`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
    logic [31:0] r_sat_count;
    logic [32:0] w_sat_add;
    logic [32:0] w_sat_sum;

    always_comb begin
        w_sat_add = '0;
        for (int l = 0; l < LANES; l++) w_sat_add = w_sat_add + 33'(r_out_sat[l]);
    end

    assign w_sat_sum = {1'b0, r_sat_count} + w_sat_add;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (i_sat_count_clr) begin
            r_sat_count <= '0;
        end else if (r_s2_valid && i_out_ready) begin
            r_sat_count <= w_sat_sum[32] ? '1 : w_sat_sum[31:0];
        end
    end

    assign o_sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_fixed_point_convert_stream.sv
// Bench for fixed_point_convert_stream at default parameters: vector table, backpressure, reset, and
// the saturation counter when FIXED_POINT_CONVERT_SAT_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_fixed_point_convert_stream;

    localparam int LANES = 3;
    localparam int IN_W  = 64;
    localparam int OUT_W = 32;

    typedef struct {
        string                  name;
        logic [LANES*IN_W-1:0]  data;
        logic [1:0]             round;
        logic [LANES*OUT_W-1:0] expData;
        logic [LANES-1:0]       expSat;
    } vec_t;

    logic                   clk;
    logic                   rst;
    logic                   i_in_valid;
    logic                   o_in_ready;
    logic [LANES*IN_W-1:0]  i_in_data;
    logic [1:0]             i_in_round;
    logic                   o_out_valid;
    logic                   i_out_ready;
    logic [LANES*OUT_W-1:0] o_out_data;
    logic [LANES-1:0]       o_out_sat;
`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
    logic [31:0]            o_sat_count;
    logic                   i_sat_count_clr;
`endif

    int   assertCount = 0;
    int   failCount   = 0;
    vec_t vecs [24];
    int   nVec = 0;

    fixed_point_convert_stream dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_round  (i_in_round),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_sat   (o_out_sat)
`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
        ,
        .o_sat_count     (o_sat_count),
        .i_sat_count_clr (i_sat_count_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Common values in Q24.40: 1.5, 2048.0, -2048.0, -2049.0.
    localparam logic [63:0] IN_1P5   = 64'h0000_0180_0000_0000;
    localparam logic [63:0] IN_2048  = 64'h0008_0000_0000_0000;
    localparam logic [63:0] IN_M2048 = 64'hFFF8_0000_0000_0000;
    localparam logic [63:0] IN_M2049 = 64'hFFF7_FF00_0000_0000;

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic addVec(input string n, input logic [63:0] l2, input logic [63:0] l1,
                          input logic [63:0] l0, input logic [1:0] rm, input logic [31:0] e2,
                          input logic [31:0] e1, input logic [31:0] e0, input logic [2:0] s);
        vecs[nVec].name    = n;
        vecs[nVec].data    = {l2, l1, l0};
        vecs[nVec].round   = rm;
        vecs[nVec].expData = {e2, e1, e0};
        vecs[nVec].expSat  = s;
        nVec++;
    endtask

    // Presents one beat and returns #1 after the edge on which it was accepted.
    task automatic applyStimulus(input logic [LANES*IN_W-1:0] data, input logic [1:0] rm);
        logic hs;
        bit   done;
        done       = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = data;
        i_in_round = rm;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            hs = o_in_ready;
            @(posedge clk);
            #1;
            done = hs;
        end
        i_in_valid = 1'b0;
        if (!done) checkOutput("handshakeTimeout", 0, 1);
    endtask

    task automatic runVector(input int idx);
        applyStimulus(vecs[idx].data, vecs[idx].round);
        checkOutput({vecs[idx].name, "_latency"}, o_out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput({vecs[idx].name, "_valid"}, o_out_valid, 1);
        checkOutput({vecs[idx].name, "_data"}, o_out_data, vecs[idx].expData);
        checkOutput({vecs[idx].name, "_sat"}, o_out_sat, vecs[idx].expSat);
    endtask

    function automatic logic [LANES*IN_W-1:0] beatIn(input int k);
        logic [63:0] a;
        a = 64'(k + 1) << 40;
        return {64'd0, -a, a};
    endfunction

    function automatic logic [LANES*OUT_W-1:0] beatExp(input int k);
        logic [31:0] a;
        a = 32'(k + 1) << 20;
        return {32'd0, -a, a};
    endfunction

    initial begin
        int sent, recvd, cyc, stale;
        logic hsIn, hsOut, prevStall;
        logic [LANES*OUT_W+LANES-1:0] prevOut;

        rst         = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_in_round  = 2'b00;
        i_out_ready = 1'b0;
`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
        i_sat_count_clr = 1'b0;
`endif

        addVec("onePointFive",  0, 0, IN_1P5, 2'b00, 0, 0, 32'h0018_0000, 3'b000);
        addVec("halfLsbTrunc",  0, 0, 64'h8_0000, 2'b00, 0, 0, 32'h0, 3'b000);
        addVec("halfLsbUp",     0, 0, 64'h8_0000, 2'b01, 0, 0, 32'h1, 3'b000);
        addVec("halfLsbEven",   0, 0, 64'h8_0000, 2'b10, 0, 0, 32'h0, 3'b000);
        addVec("oneHalfTrunc",  0, 0, 64'h18_0000, 2'b00, 0, 0, 32'h1, 3'b000);
        addVec("oneHalfUp",     0, 0, 64'h18_0000, 2'b01, 0, 0, 32'h2, 3'b000);
        addVec("oneHalfEven",   0, 0, 64'h18_0000, 2'b10, 0, 0, 32'h2, 3'b000);
        addVec("oneHalfRsvd",   0, 0, 64'h18_0000, 2'b11, 0, 0, 32'h1, 3'b000);
        addVec("negHalfTrunc",  0, 0, 64'hFFFF_FFFF_FFE8_0000, 2'b00, 0, 0, 32'hFFFF_FFFE, 3'b000);
        addVec("negHalfUp",     0, 0, 64'hFFFF_FFFF_FFE8_0000, 2'b01, 0, 0, 32'hFFFF_FFFF, 3'b000);
        addVec("negHalfEven",   0, 0, 64'hFFFF_FFFF_FFE8_0000, 2'b10, 0, 0, 32'hFFFF_FFFE, 3'b000);
        addVec("pos2048",       0, 0, IN_2048, 2'b00, 0, 0, 32'h7FFF_FFFF, 3'b001);
        addVec("neg2048",       0, 0, IN_M2048, 2'b00, 0, 0, 32'h8000_0000, 3'b000);
        addVec("neg2049",       0, 0, IN_M2049, 2'b00, 0, 0, 32'h8000_0000, 3'b001);
        addVec("maxExact",      0, 0, 64'h0007_FFFF_FFF0_0000, 2'b00, 0, 0, 32'h7FFF_FFFF, 3'b000);
        addVec("nearMaxTrunc",  0, 0, 64'h0007_FFFF_FFFF_FFFF, 2'b00, 0, 0, 32'h7FFF_FFFF, 3'b000);
        addVec("roundUpOvf",    0, 0, 64'h0007_FFFF_FFFF_FFFF, 2'b01, 0, 0, 32'h7FFF_FFFF, 3'b001);
        addVec("evenUpOvf",     0, 0, 64'h0007_FFFF_FFFF_FFFF, 2'b10, 0, 0, 32'h7FFF_FFFF, 3'b001);
        addVec("laneIndep",     IN_M2049, IN_2048, IN_1P5, 2'b00,
               32'h8000_0000, 32'h7FFF_FFFF, 32'h0018_0000, 3'b110);

        #2;
        checkOutput("rstOutValid", o_out_valid, 0);
        checkOutput("rstOutData", o_out_data, 0);
        checkOutput("rstOutSat", o_out_sat, 0);
`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
        checkOutput("rstSatCount", o_sat_count, 0);
`endif
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("inReadyAfterRst", o_in_ready, 1);

        i_out_ready = 1'b1;
        for (int i = 0; i < nVec; i++) runVector(i);
        @(posedge clk);
        #1;

        $display("[TB] backpressure stream");
        sent = 0; recvd = 0; cyc = 0; prevStall = 1'b0; prevOut = '0;
        while (recvd < 10 && cyc < 300) begin
            if (prevStall) begin
                checkOutput("stallValid", o_out_valid, 1);
                checkOutput("stallHold", {o_out_sat, o_out_data}, prevOut);
            end
            if (cyc >= 4 && cyc < 9) i_out_ready = 1'b0;
            else i_out_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                i_in_valid = 1'b1;
                i_in_data  = beatIn(sent);
                i_in_round = 2'b00;
            end else begin
                i_in_valid = 1'b0;
            end
            #1;
            checkOutput("bpInReady", o_in_ready, !((sent - recvd) == 2 && !i_out_ready));
            hsIn  = i_in_valid && o_in_ready;
            hsOut = o_out_valid && i_out_ready;
            if (hsOut) checkOutput("bpBeat", {o_out_sat, o_out_data}, {3'b000, beatExp(recvd)});
            prevStall = o_out_valid && !i_out_ready;
            prevOut   = {o_out_sat, o_out_data};
            @(posedge clk);
            #1;
            if (hsIn) sent++;
            if (hsOut) recvd++;
            cyc++;
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        checkOutput("bpReceived", recvd, 10);
        @(posedge clk);
        #1;
        checkOutput("bpNoDuplicate", o_out_valid, 0);

        $display("[TB] reset mid-stream");
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = beatIn(20);
        @(posedge clk);
        #1;
        i_in_data   = beatIn(21);
        @(posedge clk);
        #1;
        i_in_valid  = 1'b0;
        checkOutput("preRstValid", o_out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", o_out_valid, 0);
        checkOutput("asyncRstData", o_out_data, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        i_out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (o_out_valid) stale++;
        end
        checkOutput("noStaleBeat", stale, 0);
        checkOutput("inReadyPostRst", o_in_ready, 1);

`ifdef FIXED_POINT_CONVERT_SAT_COUNT_EN
        $display("[TB] saturation counter");
        i_sat_count_clr = 1'b1;
        @(posedge clk);
        #1;
        i_sat_count_clr = 1'b0;
        checkOutput("satCountIdleClr", o_sat_count, 0);
        applyStimulus({IN_M2049, IN_2048, IN_1P5}, 2'b00);
        applyStimulus({64'd0, 64'd0, IN_1P5}, 2'b00);
        applyStimulus({IN_2048, IN_2048, IN_2048}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("satCountFive", o_sat_count, 5);
        applyStimulus({IN_2048, IN_2048, IN_2048}, 2'b00);
        @(posedge clk);
        #1;
        checkOutput("clrBeatSat", o_out_sat, 3'b111);
        i_sat_count_clr = 1'b1;
        @(posedge clk);
        #1;
        i_sat_count_clr = 1'b0;
        checkOutput("satCountClrPriority", o_sat_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fixed_point_convert_stream.md
Name: fixed_point_convert_stream

Overview:
- Pipelined, streaming fixed-point format converter: LANES signed lanes per beat, from Q(IN_IBITS.IN_FBITS) to Q(OUT_IBITS.OUT_FBITS).
- Generalises the existing double-to-single saturating truncation to arbitrary widths, selectable rounding, per-lane saturation flags and valid/ready flow control.
- Sits between wide accumulation stages (double/quad FMA results) and single-precision consumers, e.g. plane-fit outputs to the inlier test.

Parameters:
LANES, 3, number of independent signed lanes per beat
IN_IBITS, 24, input integer bits (incl. sign)
IN_FBITS, 40, input fraction bits
OUT_IBITS, 12, output integer bits (incl. sign)
OUT_FBITS, 20, output fraction bits

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  converter can accept a beat
in_data  in  LANES*(IN_IBITS+IN_FBITS)  packed signed lanes, lane 0 in LSBs
in_round  in  2  rounding mode for this beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_data  out  LANES*(OUT_IBITS+OUT_FBITS)  converted lanes, lane 0 in LSBs
out_sat  out  LANES  per-lane saturation occurred

Behaviour:
- Reset (async assert, sync release): both stage valids 0; out_valid=0, out_data=0, out_sat=0; in_ready=1 from the first cycle after reset.
- Two-stage pipeline. S1 does shift and rounding increment into a widened intermediate. S2 does range check and clamp.
- Latency is exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - Transfer occurs when valid&&ready.
  - out_valid/out_data/out_sat hold stable while out_valid&&!out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is a combinational path from out_ready; no other comb in->out paths.
  - S1 advances into S2 when S2 is empty or S2 drains the same cycle.
  - Simultaneous accept and drain with a full pipeline loses no beat.
- in_round is captured with the beat and travels with it.
- Shift: D = IN_FBITS - OUT_FBITS.
  - D>0: arithmetic right shift by D, then round.
  - D<=0: left shift by -D. This is exact; rounding is ignored.
- Rounding modes (D>0), where G = bit D-1 of the input and S = OR of bits D-2..0:
  - 00 truncate toward -inf (plain arithmetic shift; matches the existing double_to_single).
  - 01 round half up: add G.
  - 10 round half to even: add G&&(S||LSB).
  - 11 reserved; behaves as 00.
- The intermediate is one bit wider than the shifted value, so a rounding carry cannot wrap.
- Saturation: if the intermediate lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], where OUT_W = OUT_IBITS+OUT_FBITS:
  - clamp to the most negative or most positive code by sign;
  - set out_sat[lane]=1; otherwise out_sat[lane]=0.
  - This includes overflow caused by round-up.
- Lanes are fully independent; one lane saturating does not affect the others.
- Reset mid-operation discards all in-flight beats immediately.

Optional Feature:
- Macro FIXED_POINT_CONVERT_SAT_COUNT_EN.
- When defined:
  - Adds output port sat_count (32 bits) and input port sat_count_clr (1 bit).
  - sat_count increments by the number of lanes with out_sat set, once per output handshake.
  - It saturates at 0xFFFFFFFF and does not wrap.
  - sat_count_clr zeroes it synchronously; clr has priority over a same-cycle increment.
  - rst zeroes it.
- When undefined: neither port exists, no counter logic is built, and all other behaviour is identical.

Test Plan:
- Default params, mode 00, lane0 = 1.5 (raw 0x0180_0000_0000), out_ready=1 -> 2 cycles later lane0 = 0x0018_0000, out_sat=0.
- Lane0 raw 0x8_0000 (half output LSB): modes 00/01/10 -> 0/1/0. Raw 0x18_0000 (1.5 LSB): modes 00/01/10 -> 1/2/2. Mode 11 -> same as mode 00.
- Saturation, lane0: 2048.0 -> 0x7FFF_FFFF with sat=1. -2048.0 -> 0x8000_0000 with sat=0. -2049.0 -> 0x8000_0000 with sat=1. Raw 2^51-1 in mode 01 (round-up overflow) -> 0x7FFF_FFFF with sat=1. Other lanes = 0 with sat=0 throughout.
- Backpressure: stream 10 beats with out_ready toggled randomly and held low for 5 cycles -> all 10 emerged in order, none dropped or duplicated, outputs stable while stalled, in_ready=0 only when both stages are full and out_ready=0.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 asynchronously and no stale beat after release.
- With FIXED_POINT_CONVERT_SAT_COUNT_EN: 3 beats with 2, 0 and 3 saturating lanes -> sat_count=5; pulse sat_count_clr during a saturating handshake -> 0.
